// File: rtl/apb_pkg.sv
// Shared APB types and constants for the N-master APB arbiter family.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] paddr;
    logic [APB_DATA_W-1:0] pwdata;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  perr;
  } apb_rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_mux_n_if.sv
// Bundle of APB lanes: LANES=N for the master side, LANES=1 for the target side.
interface apb_master_mux_n_if
  import apb_pkg::*;
#(
  parameter int LANES = 1
);

  logic [LANES*APB_ADDR_W-1:0] paddr;
  logic [LANES*APB_DATA_W-1:0] pwdata;
  logic [LANES-1:0]            psel;
  logic [LANES-1:0]            penable;
  logic [LANES-1:0]            pwrite;
  logic [LANES*APB_DATA_W-1:0] prdata;
  logic [LANES-1:0]            pready;
  logic [LANES-1:0]            perr;

  modport master (
    output paddr, pwdata, psel, penable, pwrite,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pwdata, psel, penable, pwrite,
    output prdata, pready, perr
  );

endinterface

// File: rtl/apb_rr_select.sv
// Round-robin pick: first eligible index after last_grant, wrapping modulo N.
module apb_rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  localparam int SEL_W = $clog2(N);

  always_comb begin
    int               idx;
    logic [SEL_W-1:0] sel;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    // last_grant is always a valid index, so one subtraction suffices for the wrap
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N) idx = idx - N;
      sel = SEL_W'(idx);
      if (!found && eligible[sel]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/apb_master_mux_n.sv
// N-master APB arbiter/mux: registered master requests, round-robin grant,
// one target transaction at a time, optional access-phase timeout.
module apb_master_mux_n
  import apb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int MIDX_W         = 3,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TMO_W          = 8
) (
  input  logic                      clk,
  input  logic                      clk__enable,
  input  logic                      reset_n,
  apb_master_mux_n_if.slave         apb_m,
  apb_master_mux_n_if.master        apb_t,
  output logic                      grant_active,
  output logic [MIDX_W-1:0]         grant_idx
);

  localparam int               SEL_W    = $clog2(NUM_MASTERS);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

  apb_req_t [NUM_MASTERS-1:0] req_vec;
  apb_rsp_t                   resp_reg [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]     eligible;

  apb_state_e        state_reg;
  apb_req_t          tgt_req_reg;
  logic [MIDX_W-1:0] last_grant_reg;
  logic [MIDX_W-1:0] grant_idx_reg;
  logic              busy_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;

  logic              found;
  logic [MIDX_W-1:0] winner;
  logic [SEL_W-1:0]  winner_sel;
  logic [SEL_W-1:0]  grant_sel;

  assign winner_sel = winner[SEL_W-1:0];
  assign grant_sel  = grant_idx_reg[SEL_W-1:0];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_port
    apb_req_t req_reg;

    // A completing request is dropped even if the master still holds psel this cycle
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        req_reg <= '0;
      end else if (clk__enable) begin
        if (apb_m.psel[gi] || req_reg.psel) begin
          req_reg.paddr   <= apb_m.paddr[gi*APB_ADDR_W +: APB_ADDR_W];
          req_reg.pwdata  <= apb_m.pwdata[gi*APB_DATA_W +: APB_DATA_W];
          req_reg.psel    <= apb_m.psel[gi];
          req_reg.penable <= apb_m.penable[gi];
          req_reg.pwrite  <= apb_m.pwrite[gi];
        end
        if (resp_reg[gi].pready) req_reg.psel <= 1'b0;
      end
    end

    assign req_vec[gi]  = req_reg;
    assign eligible[gi] = req_reg.psel & ~resp_reg[gi].pready;

    assign apb_m.prdata[gi*APB_DATA_W +: APB_DATA_W] = resp_reg[gi].prdata;
    assign apb_m.pready[gi]                          = resp_reg[gi].pready;
    assign apb_m.perr[gi]                            = resp_reg[gi].perr;
  end

  apb_rr_select #(
    .N     (NUM_MASTERS),
    .IDX_W (MIDX_W)
  ) u_rr_select (
    .eligible   (eligible),
    .last_grant (last_grant_reg),
    .found      (found),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      tgt_req_reg    <= '0;
      last_grant_reg <= '0;
      grant_idx_reg  <= '0;
      busy_reg       <= 1'b0;
      tmo_cnt_reg    <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) resp_reg[i] <= '0;
    end else if (clk__enable) begin
      for (int i = 0; i < NUM_MASTERS; i++) resp_reg[i].pready <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (found) begin
            tgt_req_reg         <= req_vec[winner_sel];
            tgt_req_reg.psel    <= 1'b1;
            tgt_req_reg.penable <= 1'b0;
            grant_idx_reg       <= winner;
            last_grant_reg      <= winner;
            busy_reg            <= 1'b1;
            state_reg           <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          tgt_req_reg.penable <= 1'b1;
          tmo_cnt_reg         <= '0;
          state_reg           <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (apb_t.pready[0]) begin
            resp_reg[grant_sel].prdata <= apb_t.prdata;
            resp_reg[grant_sel].perr   <= apb_t.perr[0];
            resp_reg[grant_sel].pready <= 1'b1;
            tgt_req_reg.psel           <= 1'b0;
            tgt_req_reg.penable        <= 1'b0;
            busy_reg                   <= 1'b0;
            state_reg                  <= ST_IDLE;
          end else if (TMO_EN && (tmo_cnt_reg == TMO_LAST)) begin
            // Stalled target: complete the transfer locally with an error
            resp_reg[grant_sel].prdata <= '0;
            resp_reg[grant_sel].perr   <= 1'b1;
            resp_reg[grant_sel].pready <= 1'b1;
            tgt_req_reg.psel           <= 1'b0;
            tgt_req_reg.penable        <= 1'b0;
            busy_reg                   <= 1'b0;
            state_reg                  <= ST_IDLE;
          end else if (tmo_cnt_reg != '1) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign apb_t.paddr   = tgt_req_reg.paddr;
  assign apb_t.pwdata  = tgt_req_reg.pwdata;
  assign apb_t.psel    = tgt_req_reg.psel;
  assign apb_t.penable = tgt_req_reg.penable;
  assign apb_t.pwrite  = tgt_req_reg.pwrite;

  assign grant_active = busy_reg;
  assign grant_idx    = grant_idx_reg;

endmodule

// File: tb/tb_apb_master_mux_n.sv
// Directed bench for apb_master_mux_n: 4 masters, 4-cycle access timeout, scripted target.
module tb_apb_master_mux_n;
  import apb_pkg::*;

  localparam int NM = 4;

  logic       clk = 1'b0;
  logic       clk__enable;
  logic       reset_n;
  logic       grant_active;
  logic [2:0] grant_idx;

  apb_master_mux_n_if #(.LANES(NM)) m_bus ();
  apb_master_mux_n_if #(.LANES(1))  t_bus ();

  logic        tgt_never;
  logic        tgt_err;
  logic [31:0] tgt_rdata;
  int          tgt_wait;
  int          acc_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int pready_cnt [NM];
  int pen_cycles;
  int grant_log [$];

  always #5 clk = ~clk;

  apb_master_mux_n #(
    .NUM_MASTERS    (NM),
    .MIDX_W         (3),
    .TIMEOUT_CYCLES (4),
    .TMO_W          (8)
  ) dut (
    .clk          (clk),
    .clk__enable  (clk__enable),
    .reset_n      (reset_n),
    .apb_m        (m_bus),
    .apb_t        (t_bus),
    .grant_active (grant_active),
    .grant_idx    (grant_idx)
  );

  // Target: ready after tgt_wait access cycles, or never when tgt_never is set
  assign t_bus.pready = t_bus.psel & t_bus.penable & ~tgt_never & (acc_cycles == tgt_wait);
  assign t_bus.prdata = tgt_rdata;
  assign t_bus.perr   = tgt_err;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_cycles <= 0;
    else if (clk__enable)
      acc_cycles <= (t_bus.psel[0] && t_bus.penable[0] && !t_bus.pready[0]) ? acc_cycles + 1 : 0;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NM; i++) pready_cnt[i] <= 0;
      pen_cycles <= 0;
    end else begin
      for (int i = 0; i < NM; i++) if (m_bus.pready[i]) pready_cnt[i] <= pready_cnt[i] + 1;
      if (clk__enable && t_bus.psel[0] && !t_bus.penable[0]) grant_log.push_back(int'(grant_idx));
      if (clk__enable && t_bus.penable[0]) pen_cycles <= pen_cycles + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic wr, input logic sel);
    m_bus.paddr[m*32 +: 32]  = addr;
    m_bus.pwdata[m*32 +: 32] = wdata;
    m_bus.pwrite[m]          = wr;
    m_bus.penable[m]         = 1'b0;
    m_bus.psel[m]            = sel;
  endtask

  // lat counts the launch edge as edge 1; t_edge is the edge after which target pready was seen
  task automatic wait_pready(input string tag, input int m, input int budget,
                             output int lat, output int t_edge);
    lat    = -1;
    t_edge = -1;
    for (int e = 1; e <= budget; e++) begin
      tick();
      if (t_edge < 0 && t_bus.pready[0]) t_edge = e;
      if (m_bus.pready[m]) begin
        lat = e + 1;
        m_bus.psel[m] = 1'b0;
        break;
      end
    end
    if (lat < 0) check_val({tag, "_no_pready"}, 64'd0, 64'd1);
  endtask

  task automatic wait_penable(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int e = 1; e <= budget; e++) begin
      tick();
      if (t_bus.penable[0]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val({tag, "_no_penable"}, 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, te, gbase, pbase, n;
    int base [NM];
    bit done [NM];

    reset_n     = 1'b0;
    clk__enable = 1'b1;
    m_bus.paddr = '0; m_bus.pwdata = '0; m_bus.psel = '0; m_bus.penable = '0; m_bus.pwrite = '0;
    tgt_never = 1'b0; tgt_err = 1'b0; tgt_rdata = '0; tgt_wait = 0;
    repeat (3) tick();

    check_val("rst_psel",       64'(t_bus.psel),            64'd0);
    check_val("rst_penable",    64'(t_bus.penable),         64'd0);
    check_val("rst_active",     64'(grant_active),          64'd0);
    check_val("rst_grant_idx",  64'(grant_idx),             64'd0);
    check_val("rst_m_pready",   64'(m_bus.pready),          64'd0);
    check_val("rst_m_prdata",   64'(m_bus.prdata != '0),    64'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Single master 2 read, zero wait states
    for (int i = 0; i < NM; i++) base[i] = pready_cnt[i];
    tgt_rdata = 32'hDEAD_BEEF;
    set_req(2, 32'h100, 32'h0, 1'b0, 1'b1);
    wait_pready("t1", 2, 20, lat, te);
    check_val("t1_latency",   64'(lat),                 64'd5);
    check_val("t1_prdata",    64'(m_bus.prdata[64 +: 32]), 64'hDEAD_BEEF);
    check_val("t1_perr",      64'(m_bus.perr[2]),       64'd0);
    check_val("t1_grant_idx", 64'(grant_idx),           64'd2);
    repeat (3) tick();
    check_val("t1_m2_pulses", 64'(pready_cnt[2] - base[2]), 64'd1);
    check_val("t1_others", 64'((pready_cnt[0] - base[0]) + (pready_cnt[1] - base[1]) +
                               (pready_cnt[3] - base[3])), 64'd0);

    // Master 3 write: request fields must reach the target
    tgt_rdata = 32'h1111_2222;
    set_req(3, 32'h200, 32'hA5A5_A5A5, 1'b1, 1'b1);
    wait_pready("t1w", 3, 20, lat, te);
    check_val("t1w_latency", 64'(lat),                       64'd5);
    check_val("t1w_paddr",   64'(t_bus.paddr),               64'h200);
    check_val("t1w_pwdata",  64'(t_bus.pwdata),              64'hA5A5_A5A5);
    check_val("t1w_pwrite",  64'(t_bus.pwrite),              64'd1);
    check_val("t1w_prdata",  64'(m_bus.prdata[96 +: 32]),    64'h1111_2222);
    repeat (2) tick();

    // Round robin: last grant was 3, so all four requesting gives 0,1,2,3
    gbase = grant_log.size();
    for (int i = 0; i < NM; i++) begin
      base[i] = pready_cnt[i];
      done[i] = 1'b0;
      set_req(i, 32'h1000 + 32'(i), 32'h0, 1'b0, 1'b1);
    end
    n = 0;
    for (int e = 0; e < 80 && n < NM; e++) begin
      tick();
      for (int i = 0; i < NM; i++) begin
        if (m_bus.pready[i] && !done[i]) begin
          done[i] = 1'b1;
          m_bus.psel[i] = 1'b0;
          n++;
        end
      end
    end
    repeat (3) tick();
    check_val("rr_grants", 64'(grant_log.size() - gbase), 64'd4);
    for (int k = 0; k < NM; k++) begin
      if (grant_log.size() > gbase + k)
        check_val($sformatf("rr_order%0d", k), 64'(grant_log[gbase + k]), 64'(k));
      check_val($sformatf("rr_pulses_m%0d", k), 64'(pready_cnt[k] - base[k]), 64'd1);
    end

    // Three wait states then target error
    tgt_wait = 3; tgt_err = 1'b1; tgt_rdata = 32'h1234_5678;
    pbase = pen_cycles;
    set_req(1, 32'h300, 32'h0, 1'b0, 1'b1);
    wait_pready("t3", 1, 30, lat, te);
    check_val("t3_latency",  64'(lat),                      64'd8);
    check_val("t3_rdy_skew", 64'((lat - 1) - te),           64'd1);
    check_val("t3_penable",  64'(pen_cycles - pbase),       64'd4);
    check_val("t3_perr",     64'(m_bus.perr[1]),            64'd1);
    check_val("t3_prdata",   64'(m_bus.prdata[32 +: 32]),   64'h1234_5678);
    tgt_wait = 0; tgt_err = 1'b0;
    repeat (2) tick();

    // Timeout: master 3 (next after 1) aborts, then master 0 is served normally
    tgt_never = 1'b1; tgt_rdata = 32'h55AA_55AA;
    gbase = grant_log.size();
    pbase = pen_cycles;
    set_req(3, 32'h400, 32'h0, 1'b0, 1'b1);
    set_req(0, 32'h404, 32'h0, 1'b0, 1'b1);
    wait_pready("t4a", 3, 30, lat, te);
    check_val("t4_abort_lat", 64'(lat),                    64'd8);
    check_val("t4_penable",   64'(pen_cycles - pbase),     64'd4);
    check_val("t4_psel_drop", 64'(t_bus.psel),             64'd0);
    check_val("t4_perr",      64'(m_bus.perr[3]),          64'd1);
    check_val("t4_prdata",    64'(m_bus.prdata[96 +: 32]), 64'd0);
    tgt_never = 1'b0; tgt_rdata = 32'hCAFE_0000;
    wait_pready("t4b", 0, 30, lat, te);
    check_val("t4_next_prdata", 64'(m_bus.prdata[31:0]), 64'hCAFE_0000);
    check_val("t4_next_perr",   64'(m_bus.perr[0]),      64'd0);
    if (grant_log.size() >= gbase + 2) begin
      check_val("t4_first_grant", 64'(grant_log[gbase]),     64'd3);
      check_val("t4_next_grant",  64'(grant_log[gbase + 1]), 64'd0);
    end else begin
      check_val("t4_grant_count", 64'(grant_log.size() - gbase), 64'd2);
    end
    repeat (2) tick();

    // Clock enable low in ACCESS freezes state and the timeout counter
    tgt_never = 1'b1;
    set_req(2, 32'h500, 32'h0, 1'b0, 1'b1);
    wait_penable("t5a", 20);
    tick();
    clk__enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val($sformatf("t5_hold%0d", c),
                64'({t_bus.psel[0], t_bus.penable[0], grant_active, |m_bus.pready}), 64'b1110);
    end
    clk__enable = 1'b1;
    n = -1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (m_bus.pready[2]) begin
        n = e;
        break;
      end
    end
    m_bus.psel[2] = 1'b0;
    check_val("t5_abort_after_en", 64'(n),              64'd3);
    check_val("t5_abort_perr",     64'(m_bus.perr[2]),  64'd1);
    repeat (2) tick();

    // Asynchronous reset in the middle of an access
    set_req(0, 32'h600, 32'h0, 1'b0, 1'b1);
    wait_penable("t5b", 20);
    #2 reset_n = 1'b0;
    #1;
    check_val("t5_rst_psel",    64'(t_bus.psel),         64'd0);
    check_val("t5_rst_penable", 64'(t_bus.penable),      64'd0);
    check_val("t5_rst_active",  64'(grant_active),       64'd0);
    check_val("t5_rst_pready",  64'(m_bus.pready),       64'd0);
    check_val("t5_rst_perr",    64'(m_bus.perr),         64'd0);
    check_val("t5_rst_prdata",  64'(m_bus.prdata != '0), 64'd0);
    m_bus.psel = '0;
    tgt_never  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick();
    tgt_rdata = 32'h0BAD_F00D;
    set_req(0, 32'h604, 32'h0, 1'b0, 1'b1);
    wait_pready("t5c", 0, 20, lat, te);
    check_val("t5_post_latency", 64'(lat),                64'd5);
    check_val("t5_post_prdata",  64'(m_bus.prdata[31:0]), 64'h0BAD_F00D);
    check_val("t5_post_perr",    64'(m_bus.perr[0]),      64'd0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
